// File: rtl/sram_pkg.sv
// Shared types and helpers for the single-port SRAM controller.
package sram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned lane_count(input int unsigned data_w,
                                             input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/sram_sp_ctrl_if.sv
// Access bus between a requester and the SRAM controller.
interface sram_sp_ctrl_if
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 80,
  parameter int unsigned LANE_W = 8
) ();

  localparam int unsigned NLANE = lane_count(DATA_W, LANE_W);

  logic              csn;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [NLANE-1:0]  be;
  logic              init;
  logic              ready;
  logic [DATA_W-1:0] dout;
  logic              rvalid;
  logic              err;
  logic              init_done;

  modport master (
    output csn, wen, addr, din, be, init,
    input  ready, dout, rvalid, err, init_done
  );

  modport slave (
    input  csn, wen, addr, din, be, init,
    output ready, dout, rvalid, err, init_done
  );

endinterface

// File: rtl/sram_sp_array.sv
// DEPTH x DATA_W storage with per-lane write enables and a registered read port.
module sram_sp_array
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DEPTH  = 32768,
  parameter int unsigned DATA_W = 80,
  parameter int unsigned LANE_W = 8
) (
  input  logic                                    clk,
  input  logic                                    we,
  input  logic                                    re,
  input  logic [lane_count(DATA_W, LANE_W)-1:0]   be,
  input  logic [ADDR_W-1:0]                       addr,
  input  logic [DATA_W-1:0]                       din,
  output logic [DATA_W-1:0]                       dout
);

  localparam int unsigned NLANE = lane_count(DATA_W, LANE_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset anywhere here so a foundry macro can drop in.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < int'(NLANE); k++) begin
        if (be[k]) mem[addr][k*LANE_W +: LANE_W] <= din[k*LANE_W +: LANE_W];
      end
    end
    if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM controller: zero-fill engine, range check and read pipeline.
module sram_sp_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DEPTH   = 32768,
  parameter int unsigned DATA_W  = 80,
  parameter int unsigned LANE_W  = 8,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned INIT_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  sram_sp_ctrl_if.slave bus
);

  localparam int unsigned       NLANE   = lane_count(DATA_W, LANE_W);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fill_cnt, fill_cnt_nxt;
  logic              fill_we;
  logic              acc, rd_acc, wr_acc, in_rng;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_din, arr_dout, rdata1;
  logic [NLANE-1:0]  arr_be;
  logic              rv1, err1_r, err1_w, zero1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_cnt_nxt;
    end
  end

  // With the fill engine disabled INIT lasts one cycle, giving ready on the first edge.
  always_comb begin
    state_nxt    = state;
    fill_cnt_nxt = fill_cnt;
    fill_we      = 1'b0;
    case (state)
      INIT: begin
        if (INIT_EN != 0) begin
          fill_we = 1'b1;
          if (fill_cnt == LAST) begin
            state_nxt    = RUN;
            fill_cnt_nxt = '0;
          end else begin
            fill_cnt_nxt = fill_cnt + ADDR_W'(1);
          end
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if ((INIT_EN != 0) && bus.init) state_nxt = INIT;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign acc    = (state == RUN) && !bus.csn;
  assign rd_acc = acc && bus.wen;
  assign wr_acc = acc && !bus.wen;
  assign in_rng = {1'b0, bus.addr} < DEPTH_X;

  assign arr_we   = fill_we || (wr_acc && in_rng);
  assign arr_re   = rd_acc && in_rng;
  assign arr_addr = fill_we ? fill_cnt : bus.addr;
  assign arr_din  = fill_we ? '0 : bus.din;
  assign arr_be   = fill_we ? '1 : bus.be;

  sram_sp_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .be   (arr_be),
    .addr (arr_addr),
    .din  (arr_din),
    .dout (arr_dout)
  );

  // zero1 masks the array register for out-of-range reads and after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv1    <= 1'b0;
      err1_r <= 1'b0;
      err1_w <= 1'b0;
      zero1  <= 1'b1;
    end else begin
      rv1    <= rd_acc;
      err1_r <= rd_acc && !in_rng;
      err1_w <= wr_acc && !in_rng;
      if (rd_acc) zero1 <= !in_rng;
    end
  end

  assign rdata1 = zero1 ? '0 : arr_dout;

  if (RD_LAT == 2) begin : g_lat2
    logic              rv2, err2;
    logic [DATA_W-1:0] dout2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rv2   <= 1'b0;
        err2  <= 1'b0;
        dout2 <= '0;
      end else begin
        rv2  <= rv1;
        err2 <= err1_r;
        if (rv1) dout2 <= rdata1;
      end
    end

    assign bus.rvalid = rv2;
    assign bus.err    = err2 | err1_w;
    assign bus.dout   = dout2;
  end else begin : g_lat1
    assign bus.rvalid = rv1;
    assign bus.err    = err1_r | err1_w;
    assign bus.dout   = rdata1;
  end

  assign bus.ready     = (state == RUN);
  assign bus.init_done = (state == RUN);

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Bench for sram_sp_ctrl: two instances (DEPTH16/lat1, DEPTH12/lat2) against a scheduling model.
module tb_sram_sp_ctrl;
  import sram_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 80;
  localparam int unsigned LW = 8;
  localparam int unsigned NL = DW / LW;

  typedef logic [DW-1:0] word_t;

  typedef struct packed {
    logic  rv;
    logic  err;
    word_t data;
  } ev_t;

  typedef struct {
    logic          csn;
    logic          wen;
    logic [AW-1:0] addr;
    logic [NL-1:0] be;
    word_t         din;
    logic          rv;
    logic          err;
    word_t         dout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          csn  = 1'b1;
  logic          wen  = 1'b1;
  logic          init = 1'b0;
  logic [AW-1:0] addr = '0;
  word_t         din  = '0;
  logic [NL-1:0] be   = '0;

  int checks   = 0;
  int failures = 0;

  sram_sp_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(LW)) ifa ();
  sram_sp_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(LW)) ifb ();

  assign ifa.csn = csn;  assign ifb.csn = csn;
  assign ifa.wen = wen;  assign ifb.wen = wen;
  assign ifa.addr = addr; assign ifb.addr = addr;
  assign ifa.din = din;  assign ifb.din = din;
  assign ifa.be = be;    assign ifb.be = be;
  assign ifa.init = init; assign ifb.init = init;

  sram_sp_ctrl #(.ADDR_W(AW), .DEPTH(16), .DATA_W(DW), .LANE_W(LW), .RD_LAT(1), .INIT_EN(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  sram_sp_ctrl #(.ADDR_W(AW), .DEPTH(12), .DATA_W(DW), .LANE_W(LW), .RD_LAT(2), .INIT_EN(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic  o_ready [2];
  logic  o_done  [2];
  logic  o_rv    [2];
  logic  o_err   [2];
  word_t o_dout  [2];
  assign o_ready[0] = ifa.ready;     assign o_ready[1] = ifb.ready;
  assign o_done[0]  = ifa.init_done; assign o_done[1]  = ifb.init_done;
  assign o_rv[0]    = ifa.rvalid;    assign o_rv[1]    = ifb.rvalid;
  assign o_err[0]   = ifa.err;       assign o_err[1]   = ifb.err;
  assign o_dout[0]  = ifa.dout;      assign o_dout[1]  = ifb.dout;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%b exp=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory image, fill progress and results scheduled by latency.
  word_t mmem   [2][16];
  bit    m_run  [2];
  int    m_fill [2];
  ev_t   fut    [2][2];
  bit    e_rv   [2];
  bit    e_err  [2];
  word_t e_dout [2];

  function automatic int depth_of(input int i);
    return (i == 0) ? 16 : 12;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i]  = 1'b0;
      m_fill[i] = 0;
      fut[i][0] = '0;
      fut[i][1] = '0;
      e_rv[i]   = 1'b0;
      e_err[i]  = 1'b0;
      e_dout[i] = '0;
    end
  endtask

  task automatic model_step(input int i);
    int    d = depth_of(i);
    int    l = lat_of(i);
    ev_t   sh;
    word_t w;
    if (m_run[i] && !csn) begin
      if (int'(addr) >= d) begin
        if (wen) begin
          fut[i][l-1].rv   = 1'b1;
          fut[i][l-1].err  = 1'b1;
          fut[i][l-1].data = '0;
        end else begin
          fut[i][0].err = 1'b1;
        end
      end else if (wen) begin
        fut[i][l-1].rv   = 1'b1;
        fut[i][l-1].data = mmem[i][addr];
      end else begin
        w = mmem[i][addr];
        for (int k = 0; k < int'(NL); k++)
          if (be[k]) w[k*LW +: LW] = din[k*LW +: LW];
        mmem[i][addr] = w;
      end
    end
    sh        = fut[i][0];
    fut[i][0] = fut[i][1];
    fut[i][1] = '0;
    e_rv[i]   = sh.rv;
    e_err[i]  = sh.err;
    if (sh.rv) e_dout[i] = sh.data;
    if (m_run[i]) begin
      if (init) begin
        m_run[i]  = 1'b0;
        m_fill[i] = 0;
      end
    end else begin
      mmem[i][m_fill[i]] = '0;
      m_fill[i]++;
      if (m_fill[i] == d) m_run[i] = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk1($sformatf("m_ready%0d", i), o_ready[i], m_run[i]);
        chk1($sformatf("m_done%0d", i), o_done[i], m_run[i]);
        chk1($sformatf("m_rvalid%0d", i), o_rv[i], e_rv[i]);
        chk1($sformatf("m_err%0d", i), o_err[i], e_err[i]);
        chkw($sformatf("m_dout%0d", i), o_dout[i], e_dout[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic c, input logic w, input logic [AW-1:0] a,
                       input logic [NL-1:0] b, input word_t d, input logic in);
    csn = c; wen = w; addr = a; be = b; din = d; init = in;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, '0, '0, '0, 1'b0);
  endtask

  function automatic vec_t mk(input logic c, input logic w, input logic [AW-1:0] a,
                              input logic [NL-1:0] b, input word_t d,
                              input logic rv, input logic er, input word_t dout);
    vec_t v;
    v.csn = c; v.wen = w; v.addr = a; v.be = b; v.din = d;
    v.rv = rv; v.err = er; v.dout = dout;
    return v;
  endfunction

  localparam word_t W0  = 80'h1234_5678_9ABC_DEF0_ABCD;
  localparam word_t WF  = 80'h1234_5678_9ABC_DEF0_ABFF;
  localparam word_t D15 = 80'hA5A5_0000_1111_2222_3333;
  localparam word_t D1  = 80'h0101_0101_0101_0101_0101;
  localparam word_t D2  = 80'h0202_0202_0202_0202_0202;
  localparam word_t D3  = 80'h0303_0303_0303_0303_0303;

  vec_t tbl [10];

  initial begin
    tbl[0] = mk(1'b0, 1'b0, 4'd5,  10'h3FF, W0,         1'b0, 1'b0, '0);
    tbl[1] = mk(1'b0, 1'b0, 4'd5,  10'h001, 80'hFF,     1'b0, 1'b0, '0);
    tbl[2] = mk(1'b0, 1'b1, 4'd5,  10'h000, '0,         1'b1, 1'b0, WF);
    tbl[3] = mk(1'b1, 1'b1, 4'd0,  10'h000, '0,         1'b0, 1'b0, WF);
    tbl[4] = mk(1'b0, 1'b1, 4'd0,  10'h000, '0,         1'b1, 1'b0, '0);
    tbl[5] = mk(1'b0, 1'b0, 4'd2,  10'h000, '1,         1'b0, 1'b0, '0);
    tbl[6] = mk(1'b0, 1'b1, 4'd2,  10'h000, '0,         1'b1, 1'b0, '0);
    tbl[7] = mk(1'b0, 1'b0, 4'd15, 10'h3FF, D15,        1'b0, 1'b0, '0);
    tbl[8] = mk(1'b0, 1'b1, 4'd15, 10'h000, '0,         1'b1, 1'b0, D15);
    tbl[9] = mk(1'b1, 1'b1, 4'd0,  10'h000, '0,         1'b0, 1'b0, D15);

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Fill of the 16-deep instance holds ready low for exactly 16 edges.
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk1("fill_ready", ifa.ready, c == 16);
    end

    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b1, AW'(a), '0, '0, 1'b0);
      tick();
      chk1("zero_rv", ifa.rvalid, 1'b1);
      chkw("zero_dout", ifa.dout, '0);
    end
    idle();
    tick();
    tick();

    for (int n = 0; n < 10; n++) begin
      drive(tbl[n].csn, tbl[n].wen, tbl[n].addr, tbl[n].be, tbl[n].din, 1'b0);
      tick();
      chk1($sformatf("tbl%0d_rv", n), ifa.rvalid, tbl[n].rv);
      chk1($sformatf("tbl%0d_err", n), ifa.err, tbl[n].err);
      chkw($sformatf("tbl%0d_dout", n), ifa.dout, tbl[n].dout);
    end
    tick();

    // Back-to-back reads on the two-cycle instance.
    drive(1'b0, 1'b0, 4'd1, '1, D1, 1'b0); tick();
    drive(1'b0, 1'b0, 4'd2, '1, D2, 1'b0); tick();
    drive(1'b0, 1'b0, 4'd3, '1, D3, 1'b0); tick();
    drive(1'b0, 1'b1, 4'd1, '0, '0, 1'b0); tick();
    chk1("b2b_rv0", ifb.rvalid, 1'b0);
    drive(1'b0, 1'b1, 4'd2, '0, '0, 1'b0); tick();
    chk1("b2b_rv1", ifb.rvalid, 1'b1);
    chkw("b2b_d1", ifb.dout, D1);
    drive(1'b0, 1'b1, 4'd3, '0, '0, 1'b0); tick();
    chk1("b2b_rv2", ifb.rvalid, 1'b1);
    chkw("b2b_d2", ifb.dout, D2);
    idle(); tick();
    chk1("b2b_rv3", ifb.rvalid, 1'b1);
    chkw("b2b_d3", ifb.dout, D3);
    tick();
    chk1("b2b_rv_end", ifb.rvalid, 1'b0);
    chkw("b2b_hold", ifb.dout, D3);

    // Out-of-range read and write on the 12-deep instance.
    drive(1'b0, 1'b1, 4'd13, '0, '0, 1'b0); tick();
    chk1("oob_rd_early", ifb.rvalid, 1'b0);
    idle(); tick();
    chk1("oob_rd_rv", ifb.rvalid, 1'b1);
    chk1("oob_rd_err", ifb.err, 1'b1);
    chkw("oob_rd_dout", ifb.dout, '0);
    drive(1'b0, 1'b0, 4'd13, '1, '1, 1'b0); tick();
    chk1("oob_wr_err", ifb.err, 1'b1);
    drive(1'b0, 1'b1, 4'd1, '0, '0, 1'b0); tick();
    chk1("oob_wr_err_clr", ifb.err, 1'b0);
    idle(); tick();
    chkw("oob_wr_intact", ifb.dout, D1);

    // Re-fill requested alongside a read: the read still sees old data.
    drive(1'b0, 1'b0, 4'd3, '1, 80'h55, 1'b0); tick();
    drive(1'b0, 1'b1, 4'd3, '0, '0, 1'b1); tick();
    chk1("init_rd_rv", ifa.rvalid, 1'b1);
    chkw("init_rd_dout", ifa.dout, 80'h55);
    chk1("init_rd_ready", ifa.ready, 1'b0);
    idle();
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk1("refill_ready", ifa.ready, c == 16);
    end
    drive(1'b0, 1'b1, 4'd3, '0, '0, 1'b0); tick();
    chkw("refill_dout", ifa.dout, '0);

    // Reset in the middle of a fill aborts it and restarts from address 0.
    drive(1'b0, 1'b0, 4'd5, '1, WF, 1'b0); tick();
    drive(1'b0, 1'b1, 4'd5, '0, '0, 1'b0); tick();
    idle(); tick();
    chkw("pre_rst_dout", ifa.dout, WF);
    drive(1'b1, 1'b1, '0, '0, '0, 1'b1); tick();
    idle();
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk1("rst_ready", ifa.ready, 1'b0);
    chk1("rst_done", ifa.init_done, 1'b0);
    chk1("rst_rv", ifa.rvalid, 1'b0);
    chk1("rst_err", ifa.err, 1'b0);
    chkw("rst_dout_a", ifa.dout, '0);
    chkw("rst_dout_b", ifb.dout, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk1("rst_refill_ready", ifa.ready, c == 16);
    end

    // Randomized traffic, including occasional re-fill requests.
    for (int n = 0; n < 600; n++) begin
      csn  = ($urandom_range(0, 3) == 0);
      wen  = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 15));
      be   = NL'($urandom);
      din  = DW'({$urandom, $urandom, $urandom});
      init = ($urandom_range(0, 79) == 0);
      tick();
    end
    idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_sp_ctrl.md
SRAM_SP_CTRL -- requirements
Module: sram_sp_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, address width.
REQ-002 SHALL have parameter DEPTH, default 32768, word count (<= 2**ADDR_W).
REQ-003 SHALL have parameter DATA_W, default 80, word width.
REQ-004 SHALL have parameter LANE_W, default 8, write-lane width; DATA_W SHALL be a multiple of LANE_W (NLANE = DATA_W/LANE_W).
REQ-005 SHALL have parameter RD_LAT, default 1, read latency; legal values 1 or 2.
REQ-006 SHALL have parameter INIT_EN, default 1, enables the zero-fill engine.
REQ-007 iClk  input  1  single clock; all state changes on its rising edge.
REQ-008 iReset  input  1  asynchronous, active-high reset.
REQ-009 iCsn  input  1  chip select, active low.
REQ-010 iWen  input  1  write enable, active low (iCsn=0,iWen=0 write; iCsn=0,iWen=1 read; iCsn=1 idle).
REQ-011 iAddr  input  ADDR_W  word address.
REQ-012 iDin  input  DATA_W  write data.
REQ-013 iBe  input  NLANE  per-lane write enable, active high.
REQ-014 iInit  input  1  one-cycle request to re-run zero-fill.
REQ-015 oReady  output  1  accesses accepted this cycle.
REQ-016 oDout  output  DATA_W  read data.
REQ-017 oRvalid  output  1  one-cycle pulse marking new oDout.
REQ-018 oErr  output  1  one-cycle pulse: accepted access had iAddr >= DEPTH.
REQ-019 oInitDone  output  1  high while the state is RUN.

Function
REQ-020 SHALL implement FSM states INIT and RUN; INIT -> RUN on the edge that writes the last address; RUN -> INIT on iInit=1 (INIT_EN=1 only); iInit ignored during INIT or when INIT_EN=0.
REQ-021 In INIT, SHALL write all-zero words to addresses 0..DEPTH-1 ascending, one per cycle; fill takes exactly DEPTH cycles; counter SHALL not wrap past DEPTH-1.
REQ-022 oReady SHALL be 1 only in RUN; iCsn/iWen SHALL be ignored when oReady=0 (no write, no oRvalid).
REQ-023 An accepted write SHALL update only lanes with iBe[k]=1; lanes with iBe[k]=0 keep prior contents; iBe=0 is a legal no-op write.
REQ-024 An accepted read SHALL present Mem[iAddr] on oDout with oRvalid=1 exactly RD_LAT cycles after the accepting edge; back-to-back reads SHALL sustain one result per cycle.
REQ-025 oDout SHALL hold its last value when no read completes, including during writes and INIT.
REQ-026 Read data SHALL reflect all writes accepted in earlier cycles (no read-during-write hazard: single port, one access per cycle).
REQ-027 Accepted access with iAddr >= DEPTH: write SHALL be dropped, read SHALL return zero with oRvalid, and oErr SHALL pulse aligned with where oRvalid would be (RD_LAT after accept for reads, 1 cycle for writes).
REQ-028 iInit in the same cycle as an accepted access: the access SHALL complete (read still returns pre-fill data); fill starts on the next cycle.
REQ-029 Reads in the RD_LAT pipeline when INIT is entered SHALL still complete with their captured data.

Reset
REQ-030 On iReset=1, immediately: oDout=0, oRvalid=0, oErr=0, oReady=0, oInitDone=0, fill counter=0, read pipeline cleared.
REQ-031 After release, state SHALL be INIT if INIT_EN=1, else RUN (oReady=1 on the first clock edge after release).
REQ-032 Reset asserted mid-fill SHALL abort the fill; fill restarts at address 0 after release.
REQ-033 Memory array contents SHALL not be reset; only the fill engine clears them.

Structure
REQ-034 Shared package sram_pkg SHALL hold the state enum (INIT, RUN) and a lane-count constant function.
REQ-035 Storage SHALL be a sub-module sram_sp_array (DEPTH x DATA_W, per-lane write enables, registered read, no reset) so a foundry macro can replace it.
REQ-036 Control FSM, fill counter, range check and the RD_LAT=2 output stage SHALL live in sram_sp_ctrl.

Verification
REQ-037 Reset, INIT_EN=1, DEPTH=16 -> oReady=0 for 16 cycles, then oInitDone=1; reads of all 16 addresses return 0.
REQ-038 Write 0x1234..ABCD to addr 5 with iBe=all ones, then iBe=0b0000000001 writing 0xFF in lane 0 -> read addr 5 returns original word with lane 0 = 0xFF, oRvalid exactly RD_LAT cycles after accept.
REQ-039 RD_LAT=2, reads of addrs 1,2,3 on consecutive cycles -> three consecutive oRvalid pulses with matching data; oDout holds afterwards.
REQ-040 DEPTH=12, read addr 13 -> oDout=0, oRvalid=1, oErr=1; write to addr 13 -> oErr pulse, no array change.
REQ-041 iReset pulsed at fill address 7 -> outputs zero immediately; fill restarts at 0 and takes the full DEPTH cycles.
REQ-042 iInit with a read of addr 3 (data 0x55) in the same cycle -> read returns 0x55, then fill runs; a later read of addr 3 returns 0.
